// File: rtl/dft_bin_sweeper.sv
// dft_bin_sweeper: sweeps every bin per sample into leaky sin/cos accumulators.
// DFT_SWEEP_SATURATE_EN clamps accumulator updates; by default they wrap.
module dft_bin_sweeper #(
  parameter int N = 16,
  parameter int BINS = 24,
  parameter int ACC_W = 24,
  parameter int DECAY_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [N-1:0]       sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic [$clog2(BINS)-1:0]   lut_bin,
  output logic                      lut_incr,
  input  logic signed [N-1:0]       sin_val,
  input  logic signed [N-1:0]       cos_val,
  output logic                      res_valid,
  output logic [$clog2(BINS)-1:0]   res_bin,
  output logic signed [ACC_W-1:0]   res_re,
  output logic signed [ACC_W-1:0]   res_im
);
  localparam int BW = $clog2(BINS);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  state_t state, state_n;
  logic [BW-1:0] cnt, cnt_n, p_bin;
  logic signed [N-1:0] s;
  logic signed [2*N-1:0] m_re, m_im;
  logic signed [N:0] p_re, p_im;
  logic p_v;
  logic signed [ACC_W-1:0] acc_re [BINS];
  logic signed [ACC_W-1:0] acc_im [BINS];
  logic signed [ACC_W-1:0] n_re, n_im;
  // Two guard bits absorb acc + p - acc/2^D before the wrap or clamp
  function automatic logic signed [ACC_W-1:0] upd(input logic signed [ACC_W-1:0] a,
                                                  input logic signed [N:0] p);
    logic signed [ACC_W+1:0] sum;
    sum = (ACC_W+2)'(a) + (ACC_W+2)'(p) - (ACC_W+2)'(a >>> DECAY_SHIFT);
`ifdef DFT_SWEEP_SATURATE_EN
    return (sum[ACC_W+1:ACC_W-1] == {3{sum[ACC_W+1]}}) ? sum[ACC_W-1:0]
         : {sum[ACC_W+1], {(ACC_W-1){~sum[ACC_W+1]}}};
`else
    return sum[ACC_W-1:0];
`endif
  endfunction
  always_comb begin
    state_n = state;
    cnt_n = '0;
    case (state)
      IDLE:  state_n = sample_valid ? SWEEP : IDLE;
      SWEEP: begin
        state_n = (cnt == BW'(BINS-1)) ? DRAIN : SWEEP;
        cnt_n = (cnt == BW'(BINS-1)) ? '0 : cnt + 1'b1;
      end
      DRAIN: begin
        state_n = cnt[0] ? IDLE : DRAIN;
        cnt_n = cnt[0] ? '0 : cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign sample_ready = state == IDLE;
  assign lut_incr = state == SWEEP;
  assign lut_bin = lut_incr ? cnt : '0;
  assign m_re = s * cos_val;
  assign m_im = s * sin_val;
  assign n_re = upd(acc_re[p_bin], p_re);
  assign n_im = upd(acc_im[p_bin], p_im);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      s <= '0;
      p_v <= 1'b0;
      p_bin <= '0;
      p_re <= '0;
      p_im <= '0;
      res_valid <= 1'b0;
      res_bin <= '0;
      res_re <= '0;
      res_im <= '0;
      for (int i = 0; i < BINS; i++) begin
        acc_re[i] <= '0;
        acc_im[i] <= '0;
      end
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (sample_valid && sample_ready) s <= sample_in;
      p_v <= lut_incr;
      p_bin <= lut_bin;
      p_re <= m_re[2*N-1:N-1];
      p_im <= m_im[2*N-1:N-1];
      res_valid <= p_v;
      if (p_v) begin
        acc_re[p_bin] <= n_re;
        acc_im[p_bin] <= n_im;
        res_bin <= p_bin;
        res_re <= n_re;
        res_im <= n_im;
      end
    end
  end
endmodule
